pe_leaf_controller: RTL and testbench
=====================================

// Module: pe_leaf_controller
// PURPOSE
//  Per-PE control endpoint on the LOCAL port of a leaf quadtree router; far end of the root controller's protocol.
//  Decodes CONFIG/CALC/FIN_BROADCAST/FIN_COMP flits from the root and drives config writes and phase strobes into the PE core.
//  Returns FIN_BROADCAST/FIN_COMP reports upstream, tagged with PE_ID.
//  Muxes core activation flits onto the same credit-controlled output port.
// PARAMETERS
//  PE_ID        0   this PE's index (0..63); matched against CONFIG addr[15:10] and sent in report data[15:0]
//  CFG_AW       10  local config address width (CONFIG addr[9:0])
//  FIFO_DEPTH   `ROUTER_FIFO_DEPTH  initial downstream credit count
// PORTS
//  clk               in   1   system clock
//  rst_n             in   1   asynchronous reset, active low
//  in_data_valid     in   1   flit from router valid; always accepted
//  in_data           in   36  flit: [35:32] info, [31:16] addr, [15:0] data
//  upstream_credit   out  1   credit return to router, one per accepted flit
//  out_data_valid    out  1   flit to router valid
//  out_data          out  36  flit to router
//  downstream_credit in   1   credit returned by router
//  cfg_wr_en         out  1   config write strobe to PE core
//  cfg_addr          out  10  config local address
//  cfg_data          out  16  config data
//  comp_start        out  1   1-cycle pulse: layer computation starts
//  bcast_done        in   1   1-cycle pulse: core finished local activation broadcast
//  bcast_all_done    out  1   1-cycle pulse: all PEs have finished broadcasting
//  comp_done         in   1   1-cycle pulse: core finished computation
//  layer_done        out  1   1-cycle pulse: all PEs have finished computation
//  act_valid/act_data/act_rdy  in/in/out  1/36/1  core activation flit; transfer when valid&&rdy
//  proto_err         out  1   sticky flag: unexpected flit or strobe
//  stat_comp_cycles  out  16  CALC-to-FIN_COMP cycle count (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: all outputs 0; state IDLE; credit count = FIFO_DEPTH; proto_err = 0.
//    Reset mid-layer aborts the layer without emitting pending reports.
//  - Input path: every valid flit is consumed in its cycle; upstream_credit is a registered pulse at t+1.
//  - Credit counter: decrements on a flit send and increments on downstream_credit; both in one cycle = hold.
//    Sending is gated by count>0; never underflows.
//  - Output path is combinational from state and act_*, as are act_rdy and the counter decrement.
//  - States and transitions:
//    IDLE --CALC--> BCAST; comp_start pulses at t+1.
//    BCAST --bcast_done--> SEND_FB.
//    SEND_FB: when credit>0, emit {FIN_BROADCAST, 16'h0, PE_ID zero-ext}, then go to WAIT_FB.
//    WAIT_FB --rx FIN_BROADCAST--> COMP; bcast_all_done pulses at t+1.
//    COMP --comp_done--> SEND_FC.
//    SEND_FC: when credit>0, emit {FIN_COMP, 16'h0, PE_ID}, then go to WAIT_FC.
//    WAIT_FC --rx FIN_COMP--> IDLE; layer_done pulses at t+1.
//  - CONFIG in IDLE with addr[15:10]==PE_ID: cfg_wr_en/addr/data registered at t+1.
//    CONFIG in IDLE with a non-matching addr: ignored, not an error.
//  - act_rdy = (state in BCAST or COMP) && credit>0. It is 0 in SEND_*, so the report flit has priority.
//  - Errors set proto_err, and the flit or strobe is otherwise ignored (credit still returned):
//    any flit not listed for the current state; CONFIG outside IDLE;
//    bcast_done outside BCAST; comp_done outside COMP.
//  - bcast_done and a flit arriving in the same cycle are handled independently.
// CONFIGURATION
//  `PE_CTRL_STATS_EN defined:
//    16-bit counter clears on CALC, increments every cycle outside IDLE, saturates at 16'hFFFF.
//    stat_comp_cycles holds the last value after layer_done.
//  Not defined: stat_comp_cycles tied to 0 and no counter logic; port list unchanged.
// STRUCTURE
//  - Shared package (router.vh/pe.vh): flit field offsets, ROUTER_INFO_* codes,
//    ROUTER_FIFO_DEPTH, CREDIT_CNT_WIDTH, and the state encodings (3 bits).
//  - One sub-module: pe_credit_counter (init value, inc, dec, count>0 output).
// TESTING
//  1. CONFIG addr=16'h0805 (PE_ID=2), data=16'hBEEF -> t+1 cfg_wr_en=1, cfg_addr=5, data=BEEF, upstream_credit=1.
//     Same flit with addr=16'h0C05 -> no write, no error.
//  2. Full layer, PE_ID=2: CALC -> comp_start; bcast_done -> out flit {FIN_BROADCAST,0,16'h0002};
//     rx FIN_BROADCAST -> bcast_all_done; comp_done -> {FIN_COMP,0,2}; rx FIN_COMP -> layer_done, state IDLE.
//  3. Credit starvation: consume all FIFO_DEPTH credits via act flits, then bcast_done -> stays in SEND_FB, act_rdy=0.
//     One downstream_credit -> FIN_BROADCAST sent that cycle, count returns to 0.
//  4. Simultaneous act send and downstream_credit -> count unchanged. 10 sends with no credit return -> act_rdy drops at count 0.
//  5. FIN_COMP received in BCAST, or CONFIG received in COMP -> proto_err=1 sticky, state unchanged, credit returned.
//  6. rst_n low during COMP -> IDLE, credit=FIFO_DEPTH, outputs 0; with `PE_CTRL_STATS_EN, a 40-cycle layer -> stat_comp_cycles=40.

Source files
------------

// File: rtl/pe_leaf_controller_pkg.sv
// Shared definitions for the PE leaf controller: flit layout, router info
// codes, credit sizing and controller state encoding.
package pe_leaf_controller_pkg;

  // Flit layout: [35:32] info, [31:16] addr, [15:0] data
  localparam int unsigned FLIT_W        = 36;
  localparam int unsigned INFO_W        = 4;
  localparam int unsigned DATA_W        = 16;
  localparam int unsigned FLIT_INFO_LSB = 32;
  localparam int unsigned FLIT_ADDR_LSB = 16;
  localparam int unsigned PE_ID_W       = 6;

  localparam int unsigned ROUTER_FIFO_DEPTH = 8;
  localparam int unsigned CREDIT_CNT_WIDTH  = 4;

  typedef enum logic [INFO_W-1:0] {
    ROUTER_INFO_ACT           = 4'h0,
    ROUTER_INFO_CONFIG        = 4'h1,
    ROUTER_INFO_CALC          = 4'h2,
    ROUTER_INFO_FIN_BROADCAST = 4'h3,
    ROUTER_INFO_FIN_COMP      = 4'h4
  } router_info_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_BCAST   = 3'd1,
    ST_SEND_FB = 3'd2,
    ST_WAIT_FB = 3'd3,
    ST_COMP    = 3'd4,
    ST_SEND_FC = 3'd5,
    ST_WAIT_FC = 3'd6
  } pe_state_e;

  // Upstream report flit: info code, zero address, PE index in data
  function automatic logic [FLIT_W-1:0] make_report(input router_info_e info,
                                                    input logic [DATA_W-1:0] pe_id);
    return {info, 16'h0000, pe_id};
  endfunction

endpackage

// File: rtl/pe_credit_counter.sv
// Downstream credit counter: loads INIT on reset, +1 on return, -1 on send,
// simultaneous return and send hold the count.
module pe_credit_counter #(
  parameter int unsigned CNT_W = 4,
  parameter int unsigned INIT  = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_inc,
  input  logic i_dec,
  output logic o_nonzero
);

  logic [CNT_W-1:0] r_count;

  // Credit count update; a decrement never takes the count below zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= CNT_W'(INIT);
    end else if (i_inc && !i_dec) begin
      r_count <= r_count + CNT_W'(1);
    end else if (i_dec && !i_inc && (r_count != '0)) begin
      r_count <= r_count - CNT_W'(1);
    end
  end

  assign o_nonzero = (r_count != '0);

endmodule

// File: rtl/pe_leaf_controller.sv
// Per-PE control endpoint on a leaf router LOCAL port. Decodes root flits,
// drives config writes and phase strobes, returns FIN reports and muxes
// core activation flits onto the credit-controlled output.
// Optional cycle statistics: define PE_CTRL_STATS_EN.
module pe_leaf_controller
  import pe_leaf_controller_pkg::*;
#(
  parameter int unsigned PE_ID      = 0,
  parameter int unsigned CFG_AW     = 10,
  parameter int unsigned FIFO_DEPTH = ROUTER_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_data_valid,
  input  logic [FLIT_W-1:0] in_data,
  output logic              upstream_credit,
  output logic              out_data_valid,
  output logic [FLIT_W-1:0] out_data,
  input  logic              downstream_credit,
  output logic              cfg_wr_en,
  output logic [CFG_AW-1:0] cfg_addr,
  output logic [DATA_W-1:0] cfg_data,
  output logic              comp_start,
  input  logic              bcast_done,
  output logic              bcast_all_done,
  input  logic              comp_done,
  output logic              layer_done,
  input  logic              act_valid,
  input  logic [FLIT_W-1:0] act_data,
  output logic              act_rdy,
  output logic              proto_err,
  output logic [15:0]       stat_comp_cycles
);

  localparam logic [PE_ID_W-1:0] PE_ID_ADDR = PE_ID_W'(PE_ID);
  localparam logic [DATA_W-1:0]  PE_ID_DATA = DATA_W'(PE_ID);

  pe_state_e          r_state;
  pe_state_e          w_state_next;
  logic [INFO_W-1:0]  w_info;
  logic               w_pe_match;
  logic               w_has_credit;
  logic               w_cfg_wr;
  logic               w_comp_start;
  logic               w_bcast_all;
  logic               w_layer_done;
  logic               w_err;
  logic               w_rpt_send;
  logic [FLIT_W-1:0]  w_rpt_flit;
  logic               w_act_xfer;

  assign w_info     = in_data[FLIT_INFO_LSB +: INFO_W];
  assign w_pe_match = (in_data[FLIT_ADDR_LSB + CFG_AW +: PE_ID_W] == PE_ID_ADDR);

  pe_credit_counter #(
    .CNT_W (CREDIT_CNT_WIDTH),
    .INIT  (FIFO_DEPTH)
  ) u_credit (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_inc     (downstream_credit),
    .i_dec     (out_data_valid),
    .o_nonzero (w_has_credit)
  );

  // Controller state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  // Next state, flit/strobe decode and report emission; flits and core strobes
  // are decoded independently since no state accepts both kinds of event
  always_comb begin
    w_state_next = r_state;
    w_cfg_wr     = 1'b0;
    w_comp_start = 1'b0;
    w_bcast_all  = 1'b0;
    w_layer_done = 1'b0;
    w_err        = 1'b0;
    w_rpt_send   = 1'b0;
    w_rpt_flit   = '0;

    if (in_data_valid) begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_info == ROUTER_INFO_CONFIG) begin
            w_cfg_wr = w_pe_match;
          end else if (w_info == ROUTER_INFO_CALC) begin
            w_state_next = ST_BCAST;
            w_comp_start = 1'b1;
          end else begin
            w_err = 1'b1;
          end
        end
        ST_WAIT_FB: begin
          if (w_info == ROUTER_INFO_FIN_BROADCAST) begin
            w_state_next = ST_COMP;
            w_bcast_all  = 1'b1;
          end else begin
            w_err = 1'b1;
          end
        end
        ST_WAIT_FC: begin
          if (w_info == ROUTER_INFO_FIN_COMP) begin
            w_state_next = ST_IDLE;
            w_layer_done = 1'b1;
          end else begin
            w_err = 1'b1;
          end
        end
        default: w_err = 1'b1;
      endcase
    end

    if (bcast_done) begin
      if (r_state == ST_BCAST) w_state_next = ST_SEND_FB;
      else                     w_err = 1'b1;
    end

    if (comp_done) begin
      if (r_state == ST_COMP) w_state_next = ST_SEND_FC;
      else                    w_err = 1'b1;
    end

    if ((r_state == ST_SEND_FB) && w_has_credit) begin
      w_rpt_send   = 1'b1;
      w_rpt_flit   = make_report(ROUTER_INFO_FIN_BROADCAST, PE_ID_DATA);
      w_state_next = ST_WAIT_FB;
    end else if ((r_state == ST_SEND_FC) && w_has_credit) begin
      w_rpt_send   = 1'b1;
      w_rpt_flit   = make_report(ROUTER_INFO_FIN_COMP, PE_ID_DATA);
      w_state_next = ST_WAIT_FC;
    end
  end

  // Core activations only flow in working phases, so reports take priority
  assign act_rdy        = ((r_state == ST_BCAST) || (r_state == ST_COMP)) && w_has_credit;
  assign w_act_xfer     = act_valid && act_rdy;
  assign out_data_valid = w_rpt_send || w_act_xfer;
  assign out_data       = w_rpt_send ? w_rpt_flit : (w_act_xfer ? act_data : '0);

  // Registered credit return, config write, phase pulses and sticky error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      upstream_credit <= 1'b0;
      cfg_wr_en       <= 1'b0;
      cfg_addr        <= '0;
      cfg_data        <= '0;
      comp_start      <= 1'b0;
      bcast_all_done  <= 1'b0;
      layer_done      <= 1'b0;
      proto_err       <= 1'b0;
    end else begin
      upstream_credit <= in_data_valid;
      cfg_wr_en       <= w_cfg_wr;
      if (w_cfg_wr) begin
        cfg_addr <= in_data[FLIT_ADDR_LSB +: CFG_AW];
        cfg_data <= in_data[DATA_W-1:0];
      end
      comp_start      <= w_comp_start;
      bcast_all_done  <= w_bcast_all;
      layer_done      <= w_layer_done;
      proto_err       <= proto_err | w_err;
    end
  end

`ifdef PE_CTRL_STATS_EN
  logic [15:0] r_stat;

  // Layer cycle counter: cleared by CALC, counts non-idle cycles, saturating
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat <= '0;
    end else if (w_comp_start) begin
      r_stat <= '0;
    end else if ((r_state != ST_IDLE) && (r_stat != '1)) begin
      r_stat <= r_stat + 16'd1;
    end
  end

  assign stat_comp_cycles = r_stat;
`else
  assign stat_comp_cycles = '0;
`endif

endmodule

// File: tb/tb_pe_leaf_controller.sv
// Directed self-checking bench for pe_leaf_controller (PE_ID = 2, 8 credits).
module tb_pe_leaf_controller;
  import pe_leaf_controller_pkg::*;

  localparam logic [35:0] RPT_FB = 36'h3_0000_0002;
  localparam logic [35:0] RPT_FC = 36'h4_0000_0002;
  localparam logic [3:0]  I_CONFIG = 4'h1;
  localparam logic [3:0]  I_CALC   = 4'h2;
  localparam logic [3:0]  I_FINB   = 4'h3;
  localparam logic [3:0]  I_FINC   = 4'h4;
`ifdef PE_CTRL_STATS_EN
  localparam logic [15:0] EXP_STAT = 16'd40;
`else
  localparam logic [15:0] EXP_STAT = 16'd0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_data_valid;
  logic [35:0] in_data;
  logic        upstream_credit;
  logic        out_data_valid;
  logic [35:0] out_data;
  logic        downstream_credit;
  logic        cfg_wr_en;
  logic [9:0]  cfg_addr;
  logic [15:0] cfg_data;
  logic        comp_start;
  logic        bcast_done;
  logic        bcast_all_done;
  logic        comp_done;
  logic        layer_done;
  logic        act_valid;
  logic [35:0] act_data;
  logic        act_rdy;
  logic        proto_err;
  logic [15:0] stat_comp_cycles;

  int n_total = 0;
  int n_pass  = 0;

  pe_leaf_controller #(.PE_ID(2)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .in_data_valid     (in_data_valid),
    .in_data           (in_data),
    .upstream_credit   (upstream_credit),
    .out_data_valid    (out_data_valid),
    .out_data          (out_data),
    .downstream_credit (downstream_credit),
    .cfg_wr_en         (cfg_wr_en),
    .cfg_addr          (cfg_addr),
    .cfg_data          (cfg_data),
    .comp_start        (comp_start),
    .bcast_done        (bcast_done),
    .bcast_all_done    (bcast_all_done),
    .comp_done         (comp_done),
    .layer_done        (layer_done),
    .act_valid         (act_valid),
    .act_data          (act_data),
    .act_rdy           (act_rdy),
    .proto_err         (proto_err),
    .stat_comp_cycles  (stat_comp_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_flit(input logic [3:0] info, input logic [15:0] addr, input logic [15:0] data);
    in_data_valid = 1'b1;
    in_data       = {info, addr, data};
    tick();
    in_data_valid = 1'b0;
    in_data       = '0;
  endtask

  task automatic pulse_bcast();
    bcast_done = 1'b1;
    tick();
    bcast_done = 1'b0;
  endtask

  task automatic pulse_comp();
    comp_done = 1'b1;
    tick();
    comp_done = 1'b0;
  endtask

  task automatic give_credits(input int n);
    for (int i = 0; i < n; i++) begin
      downstream_credit = 1'b1;
      tick();
    end
    downstream_credit = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; in_data_valid = 1'b0; in_data = '0; downstream_credit = 1'b0;
    bcast_done = 1'b0; comp_done = 1'b0; act_valid = 1'b0; act_data = '0;
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Reset state
    chk("rst_upcred", upstream_credit, 0);
    chk("rst_outv", out_data_valid, 0);
    chk("rst_cfgwr", cfg_wr_en, 0);
    chk("rst_err", proto_err, 0);
    chk("rst_actrdy", act_rdy, 0);
    chk("rst_credit", dut.u_credit.r_count, 8);
    chk("rst_state", dut.r_state, ST_IDLE);

    // 1. CONFIG matching and non-matching PE_ID
    send_flit(I_CONFIG, 16'h0805, 16'hBEEF);
    chk("cfg_wr", cfg_wr_en, 1);
    chk("cfg_addr", cfg_addr, 10'h005);
    chk("cfg_data", cfg_data, 16'hBEEF);
    chk("cfg_upcred", upstream_credit, 1);
    tick();
    chk("cfg_wr_pulse", cfg_wr_en, 0);
    chk("upcred_pulse", upstream_credit, 0);
    send_flit(I_CONFIG, 16'h0C05, 16'h1234);
    chk("cfg_nomatch_wr", cfg_wr_en, 0);
    chk("cfg_nomatch_err", proto_err, 0);
    chk("cfg_nomatch_cred", upstream_credit, 1);
    chk("cfg_nomatch_data", cfg_data, 16'hBEEF);

    // 2. Full layer
    send_flit(I_CALC, 16'h0, 16'h0);
    chk("comp_start", comp_start, 1);
    chk("bcast_actrdy", act_rdy, 1);
    tick();
    chk("comp_start_pulse", comp_start, 0);
    pulse_bcast();
    chk("fb_valid", out_data_valid, 1);
    chk("fb_data", out_data, RPT_FB);
    chk("fb_actrdy", act_rdy, 0);
    tick();
    chk("waitfb_valid", out_data_valid, 0);
    chk("waitfb_credit", dut.u_credit.r_count, 7);
    send_flit(I_FINB, 16'h0, 16'h0);
    chk("bcast_all_done", bcast_all_done, 1);
    chk("comp_state", dut.r_state, ST_COMP);
    pulse_comp();
    chk("fc_valid", out_data_valid, 1);
    chk("fc_data", out_data, RPT_FC);
    tick();
    chk("waitfc_credit", dut.u_credit.r_count, 6);
    give_credits(2);
    chk("credit_back", dut.u_credit.r_count, 8);
    send_flit(I_FINC, 16'h0, 16'h0);
    chk("layer_done", layer_done, 1);
    chk("layer_idle", dut.r_state, ST_IDLE);
    chk("layer_err", proto_err, 0);

    // 3. Credit starvation
    send_flit(I_CALC, 16'h0, 16'h0);
    act_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      act_data = 36'hA_0000_0000 + 36'(i);
      #1;
      chk("starve_rdy", act_rdy, 1);
      chk("starve_data", out_data, 36'hA_0000_0000 + 36'(i));
      tick();
    end
    chk("starve_rdy0", act_rdy, 0);
    chk("starve_outv0", out_data_valid, 0);
    act_valid = 1'b0;
    pulse_bcast();
    chk("sendfb_state", dut.r_state, ST_SEND_FB);
    chk("sendfb_nocred", out_data_valid, 0);
    chk("sendfb_actrdy", act_rdy, 0);
    tick();
    chk("sendfb_hold", dut.r_state, ST_SEND_FB);
    give_credits(1);
    chk("sendfb_credit1", dut.u_credit.r_count, 1);
    chk("sendfb_go", out_data_valid, 1);
    chk("sendfb_data", out_data, RPT_FB);
    tick();
    chk("sendfb_cnt0", dut.u_credit.r_count, 0);
    chk("sendfb_wait", dut.r_state, ST_WAIT_FB);
    send_flit(I_FINB, 16'h0, 16'h0);
    chk("comp_nocred_rdy", act_rdy, 0);

    // 4. Simultaneous send and return, then exhaustion by 10 sends
    give_credits(1);
    act_valid = 1'b1; act_data = 36'hB_0000_0001; downstream_credit = 1'b1;
    #1;
    chk("simul_rdy", act_rdy, 1);
    tick();
    act_valid = 1'b0; downstream_credit = 1'b0;
    chk("simul_hold", dut.u_credit.r_count, 1);
    give_credits(7);
    chk("refill", dut.u_credit.r_count, 8);
    act_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      act_data = 36'hC_0000_0000 + 36'(i);
      #1;
      chk("ten_rdy", act_rdy, (i < 8) ? 1'b1 : 1'b0);
      tick();
    end
    act_valid = 1'b0;
    chk("ten_cnt0", dut.u_credit.r_count, 0);
    pulse_comp();
    give_credits(1);
    chk("fc_after_starve", out_data, RPT_FC);
    tick();
    send_flit(I_FINC, 16'h0, 16'h0);
    chk("layer2_done", layer_done, 1);
    give_credits(8);
    chk("refill2", dut.u_credit.r_count, 8);

    // 5. Protocol errors
    send_flit(I_CALC, 16'h0, 16'h0);
    chk("err_pre", proto_err, 0);
    send_flit(I_FINC, 16'h0, 16'h0);
    chk("err_finc_bcast", proto_err, 1);
    chk("err_state_bcast", dut.r_state, ST_BCAST);
    chk("err_cred", upstream_credit, 1);
    tick();
    chk("err_sticky", proto_err, 1);
    pulse_bcast();
    tick();
    send_flit(I_FINB, 16'h0, 16'h0);
    send_flit(I_CONFIG, 16'h0805, 16'h1111);
    chk("err_cfg_comp_wr", cfg_wr_en, 0);
    chk("err_cfg_state", dut.r_state, ST_COMP);
    chk("err_cfg_cred", upstream_credit, 1);
    chk("err_cfg_credcnt", dut.u_credit.r_count, 7);

    // 6. Asynchronous reset during COMP
    rst_n = 1'b0;
    #1;
    chk("arst_state", dut.r_state, ST_IDLE);
    chk("arst_credit", dut.u_credit.r_count, 8);
    chk("arst_err", proto_err, 0);
    chk("arst_upcred", upstream_credit, 0);
    chk("arst_actrdy", act_rdy, 0);
    tick();
    rst_n = 1'b1;
    tick(); tick();
    chk("arst_outv", out_data_valid, 0);
    chk("arst_layer", layer_done, 0);
    chk("arst_stat", stat_comp_cycles, 0);

    // 40 non-idle cycles between CALC and FIN_COMP
    send_flit(I_CALC, 16'h0, 16'h0);
    repeat (17) tick();
    pulse_bcast();
    tick();
    send_flit(I_FINB, 16'h0, 16'h0);
    repeat (17) tick();
    pulse_comp();
    tick();
    send_flit(I_FINC, 16'h0, 16'h0);
    chk("stat_layer_done", layer_done, 1);
    chk("stat_count", stat_comp_cycles, EXP_STAT);
    repeat (3) tick();
    chk("stat_hold", stat_comp_cycles, EXP_STAT);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
